// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU width, MULDIV funct3 codes and sequencer state encoding.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  // {rs1 signed, rs2 signed}
  function automatic logic [1:0] op_signs(input logic [2:0] f);
    return (f == F3_MULH || f == F3_DIV || f == F3_REM) ? 2'b11 : f == F3_MULHSU ? 2'b10 : 2'b00;
  endfunction
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: one-bit-per-step shift-add multiplier / restoring divider with sign-corrected result.
module muldiv_datapath #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      fn,
  input  logic            neg,
  input  logic            rem_neg,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res
);
  import cpu_pkg::*;
  logic [2*XLEN-1:0] acc, acc_d, sh, prod;
  logic [XLEN-1:0] d, q, r;
  logic [XLEN:0] sum, trial;
  // acc is {product-high, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      d <= '0;
    end else if (load) begin
      acc <= {{XLEN{1'b0}}, a};
      d <= b;
    end else if (step) acc <= acc_d;
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? d : {XLEN{1'b0}}};
    sh = {acc[2*XLEN-2:0], 1'b0};
    trial = {acc[2*XLEN-1], sh[2*XLEN-1:XLEN]} - {1'b0, d};
    acc_d = !fn[2] ? {sum, acc[XLEN-1:1]} : trial[XLEN] ? sh : {trial[XLEN-1:0], sh[XLEN-1:1], 1'b1};
    prod = neg ? -acc_d : acc_d;
    q = neg ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    r = rem_neg ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    res = !fn[2] ? (fn == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) : fn[1] ? r : q;
  end
endmodule

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: EX-stage RV32M controller; stalls the pipeline while an iterative mul/div runs.
module ex_muldiv_sequencer #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  import cpu_pkg::*;
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  state_e state, state_d;
  logic [CW-1:0] count;
  logic [2:0] fn;
  logic [4:0] rd_q;
  logic [1:0] sg;
  logic neg, rem_neg, sa, sb, accept, step, last, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res, dp_res;
  always_comb begin
    sg = op_signs(funct3);
    sa = sg[1] & rs1_data[XLEN-1];
    sb = sg[0] & rs2_data[XLEN-1];
    a_mag = sa ? -rs1_data : rs1_data;
    b_mag = sb ? -rs2_data : rs2_data;
    div0 = funct3[2] && rs2_data == '0;
    ovf = (funct3 == F3_DIV || funct3 == F3_REM) && rs1_data == SMIN && &rs2_data;
    special = div0 || ovf;
    spec_res = div0 ? (funct3[1] ? rs1_data : '1) : (funct3[1] ? '0 : SMIN);
    accept = state == IDLE && start && !flush;
    step = state == BUSY && !flush;
    last = count == CW'(XLEN-1);
    state_d = flush ? IDLE
            : state == IDLE ? (start ? (special ? DONE : BUSY) : IDLE)
            : state == BUSY ? (last ? DONE : BUSY)
            : IDLE;
    stall = !flush && ((state == IDLE && start) || state == BUSY);
    busy = state == BUSY;
    done = state == DONE && !flush;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      fn <= '0;
      neg <= 1'b0;
      rem_neg <= 1'b0;
      rd_q <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      if (accept) begin
        count <= '0;
        fn <= funct3;
        neg <= sa ^ sb;
        rem_neg <= sa;
        rd_q <= rd_in;
      end else if (step) count <= count + 1'b1;
      if (accept && special) begin
        result <= spec_res;
        rd_out <= rd_in;
      end else if (step && last) begin
        result <= dp_res;
        rd_out <= rd_q;
      end
    end
  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk(clk), .rst(rst), .load(accept), .step(step), .fn(fn), .neg(neg), .rem_neg(rem_neg),
    .a(a_mag), .b(b_mag), .res(dp_res)
  );
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb_ex_muldiv_sequencer: directed vectors with a scoreboard queue drained by a done-driven monitor.
module tb_ex_muldiv_sequencer;
  import cpu_pkg::*;
  logic clk = 0, rst = 1, start = 0, flush = 0;
  logic [2:0] funct3 = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic [4:0] rd_in = '0;
  logic stall, busy, done;
  logic [31:0] result;
  logic [4:0] rd_out;
  int cyc = 0, n_chk = 0, n_bad = 0, done_cnt = 0, d0;
  typedef struct {logic [31:0] res; logic [4:0] rd; int due;} exp_t;
  exp_t sb[$];
  exp_t e;
  ex_muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rd_in(rd_in), .stall(stall), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 with result %h, expected no pending op", result);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
        chk("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] ex, input int lat, input bit want);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1;
    if (want) sb.push_back('{ex, rd, cyc + lat});
    @(negedge clk);
    chk("stall_accept", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_done(input int lat);
    int win_bad = 0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (stall !== 1'b1 || done !== 1'b0) win_bad++;
    end
    @(negedge clk);
    chk("stall_window", 32'(win_bad), 32'd0);
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("stall_in_done", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask
  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] ex, input int lat);
    issue(f, a, b, rd, ex, lat, 1'b1);
    wait_done(lat);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", {27'b0, rd_out}, 32'd0);
    chk("rst_flags", {29'b0, stall, busy, done}, 32'd0);
    rst = 0;
    run(F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
    run(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33);
    run(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33);
    run(F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
    run(F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33);
    run(F3_REM,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33);
    run(F3_DIVU,   32'd100,      32'd7,        5'd12, 32'd14,       33);
    run(F3_REMU,   32'd100,      32'd7,        5'd13, 32'd2,        33);
    run(F3_DIVU,   32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
    run(F3_REM,    32'd5,        32'd0,        5'd15, 32'd5,        1);
    run(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
    run(F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        1);
    issue(F3_DIV, 32'd100, 32'd7, 5'd20, 32'd0, 33, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1;
    #1;
    chk("flush_stall", {31'b0, stall}, 32'd0);
    chk("flush_busy_same_cycle", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    flush = 0;
    chk("idle_after_flush", {31'b0, busy}, 32'd0);
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("no_done_after_flush", 32'(done_cnt - d0), 32'd0);
    run(F3_MUL, 32'd3, 32'd4, 5'd9, 32'd12, 33);
    issue(F3_MUL, 32'h55, 32'd3, 5'd21, 32'hFF, 33, 1'b1);
    repeat (19) @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd_out", {27'b0, rd_out}, 32'd0);
    chk("midrst_flags", {29'b0, stall, busy, done}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    run(F3_MUL,  32'h00012345, 32'h100, 5'd3, 32'h01234500, 33);
    run(F3_DIVU, 32'd1000,     32'd10,  5'd4, 32'd100,      33);
    run(F3_MULH, 32'hFFFFFFFD, 32'd5,   5'd1, 32'hFFFFFFFF, 33);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
- Multi-cycle controller for RV32M multiply/divide operations issued to the EX stage.
- Latches operands from ID/EX and runs an iterative shift-add multiplier or restoring divider, one bit per cycle.
- Holds the pipeline with stall until the result is ready, then presents result and rd for one cycle so the EX/MEM register can capture them.
- Flush from the branch/hazard logic aborts an in-flight operation.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  M-extension op valid in ID/EX (ALUOp decoded as MULDIV)
- flush  in  1  kill current op (branch taken / pipeline flush)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  XLEN  forwarded operand 1
- rs2_data  in  XLEN  forwarded operand 2
- rd_in  in  5  destination register
- stall  out  1  hold PC, IF/ID and ID/EX
- busy  out  1  state is BUSY
- done  out  1  result valid, one-cycle pulse
- result  out  XLEN  selected product half, quotient or remainder
- rd_out  out  5  rd of the completed op

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, done=0, busy=0, result=0, rd_out=0, internal accumulators=0. Reset mid-operation drops the op silently; no done is produced.
- States: IDLE, BUSY, DONE.
- IDLE, start=1, flush=0:
  - Latch funct3 and rd_in.
  - Latch operand magnitudes and result sign:
    - Signed ops (MULH, DIV, REM): |rs1|, |rs2|.
    - MULHSU: rs1 signed, rs2 unsigned.
    - Unsigned ops: raw values.
  - Set count=0.
  - Special divide cases go straight to DONE:
    - Divisor zero: quotient=all ones, remainder=rs1.
    - Signed overflow (rs1=0x80000000, rs2=all ones, DIV/REM): quotient=0x80000000, remainder=0.
  - All other ops go to BUSY.
- BUSY, one iteration per cycle:
  - Multiply: if multiplier LSB is set, add the multiplicand into the 2*XLEN accumulator; then shift.
  - Divide (restoring): shift the remainder left, bringing in the next dividend bit; trial-subtract the divisor; set the quotient bit if the result is non-negative.
  - count increments each cycle. At count==XLEN-1, go to DONE and register the sign-corrected result:
    - Product negated if operand signs differ.
    - Quotient negated if signs differ.
    - Remainder takes the dividend's sign.
    - MUL takes the low half; MULH/MULHSU/MULHU take the high half.
- DONE: done=1 for exactly one cycle with result and rd_out stable; next state IDLE. start is ignored in DONE because ID/EX advances at the end of this cycle.
- stall = (state==IDLE && start && !flush) || state==BUSY. stall is 0 in DONE.
- Latency, counting the start-accept cycle as cycle 0:
  - Normal ops: done at cycle XLEN+1 (33); stall high for cycles 0..32.
  - Special divide cases: done at cycle 1.
- Back-to-back ops: a new start is accepted in the IDLE cycle following DONE; there are no dead cycles beyond that.
- flush:
  - Highest priority after rst, in any state: next state IDLE, and done is not asserted.
  - Forces stall=0 in the same cycle.
  - flush with start in IDLE: the op is not accepted.
- result and rd_out hold their last value outside DONE; consumers qualify them with done.
- All arithmetic is unsigned on magnitudes, with XLEN+1 bits for the trial subtract; no overflow flags are exported.

Decomposition:
- Shared package (cpu_pkg):
  - MULDIV funct3 codes.
  - State encoding IDLE/BUSY/DONE.
  - XLEN constant shared with ALU and ALU_Src_MUX.
- One sub-module, muldiv_datapath:
  - Registered accumulator/remainder/quotient.
  - Single-step add-shift and subtract-shift, selected by an is_div control.
  - Sign-correction output mux.
- The sequencer keeps the FSM, counter, special-case detect, stall/flush logic and the rd pipeline.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result=0xFFFFFFEB, done exactly at cycle 33, stall=1 for cycles 0..32, rd_out=rd_in.
- MULHU rs1=rs2=0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> result=0x00000000; MULHSU rs1=0xFFFFFFFF, rs2=2 -> result=0xFFFFFFFF.
- DIV rs1=-7, rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at cycle 1. REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1. REM with the same operands -> 0.
- Flush at cycle 10 of a DIV -> stall=0 in that cycle, IDLE next cycle, no done pulse. Then a new MUL 3*4 completes with result=12.
- rst asserted at cycle 20 of a MUL (asynchronous, mid-cycle) -> all outputs 0 immediately. Back-to-back MUL then DIVU: second op accepted the cycle after the first done, with both results correct.
